front_panel_switches: RTL

//  Downstream of the keyboard cursor stage. Turns its registered (cursor_index, cursor_action) pair into Altair

---
 rtl/front_panel_switches.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/front_panel_switches.sv
// Altair front-panel switch state from the registered keyboard cursor pair: latching toggles plus
// momentary levers with edge pulses and minimum hold. Optional auto-repeat: define FP_AUTOREPEAT_EN.
//
// state   | meaning
// IDLE    | no momentary lever asserted
// HELD    | lever asserted and still pressed at the cursor
// STRETCH | lever released early, level kept until hold_cnt reaches MIN_HOLD
module front_panel_switches #(
    parameter int                      TOGGLE_COUNT  = 17,
    parameter int                      MOM_COUNT     = 8,
    parameter int                      MIN_HOLD      = 50000,
    parameter logic [TOGGLE_COUNT-1:0] TOGGLE_INIT   = '0,
    parameter int                      REPEAT_DELAY  = 25000000,
    parameter int                      REPEAT_PERIOD = 5000000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [4:0]              cursor_index,
    input  logic [1:0]              cursor_action,
    output logic [TOGGLE_COUNT-1:0] toggle_sw,
    output logic [MOM_COUNT-1:0]    mom_up,
    output logic [MOM_COUNT-1:0]    mom_dn,
    output logic [MOM_COUNT-1:0]    mom_up_pulse,
    output logic [MOM_COUNT-1:0]    mom_dn_pulse,
    output logic                    toggle_changed
);

    localparam int                HOLD_W   = $clog2(MIN_HOLD + 1);
    localparam int                MOM_W    = (MOM_COUNT > 1) ? $clog2(MOM_COUNT) : 1;
    localparam logic [4:0]        TOG_BASE = 5'(TOGGLE_COUNT);
    localparam logic [4:0]        MOM_SPAN = 5'(MOM_COUNT);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MIN_HOLD);

    if (MIN_HOLD < 1) begin : g_bad_hold
        $error("MIN_HOLD must be at least 1");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("REPEAT_DELAY and REPEAT_PERIOD must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, HELD, STRETCH} state_t;

    state_t                  state, state_nxt;
    logic [4:0]              prev_idx;
    logic [1:0]              prev_act;
    logic [MOM_W-1:0]        mom_sel, sel_nxt;
    logic                    mom_is_up, up_nxt;
    logic [HOLD_W-1:0]       hold_cnt, hold_nxt, hold_inc;
    logic [MOM_COUNT-1:0]    up_pulse_nxt, dn_pulse_nxt;
    logic [MOM_COUNT-1:0]    mom_onehot, press_onehot;
    logic [TOGGLE_COUNT-1:0] toggle_nxt;
    logic [4:0]              mom_off;
    logic                    evt, mom_valid, is_press, rep_fire;

    assign evt          = (cursor_index != prev_idx) || (cursor_action != prev_act);
    assign mom_off      = cursor_index - TOG_BASE;
    assign mom_valid    = (cursor_index >= TOG_BASE) && (mom_off < MOM_SPAN);
    assign is_press     = evt && mom_valid && (cursor_action == 2'd1 || cursor_action == 2'd2);
    assign mom_onehot   = MOM_COUNT'(1) << mom_sel;
    assign press_onehot = MOM_COUNT'(1) << mom_off[MOM_W-1:0];
    assign hold_inc     = (hold_cnt >= HOLD_MAX) ? hold_cnt : hold_cnt + 1'b1;

    // Levels come straight from state so an async reset drops them immediately.
    assign mom_up = (state != IDLE && mom_is_up)  ? mom_onehot : '0;
    assign mom_dn = (state != IDLE && !mom_is_up) ? mom_onehot : '0;

`ifdef FP_AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    logic [REP_W-1:0] rep_cnt, rep_nxt;

    // Down-counter: loaded on press, fires at terminal count, reloads with the period.
    always_comb begin
        rep_nxt  = rep_cnt;
        rep_fire = 1'b0;
        if (is_press) begin
            rep_nxt = REP_W'(REPEAT_DELAY - 1);
        end else if (state == HELD && !evt) begin
            if (rep_cnt == '0) begin
                rep_fire = 1'b1;
                rep_nxt  = REP_W'(REPEAT_PERIOD - 1);
            end else begin
                rep_nxt = rep_cnt - 1'b1;
            end
        end else begin
            rep_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rep_cnt <= '0;
        else          rep_cnt <= rep_nxt;
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_comb begin
        toggle_nxt = toggle_sw;
        if (evt && cursor_index < TOG_BASE) begin
            case (cursor_action)
                2'd1:       toggle_nxt[cursor_index] = 1'b1;
                2'd0, 2'd2: toggle_nxt[cursor_index] = 1'b0;
                default:    ;
            endcase
        end
    end

    always_comb begin
        state_nxt    = state;
        sel_nxt      = mom_sel;
        up_nxt       = mom_is_up;
        hold_nxt     = hold_cnt;
        up_pulse_nxt = '0;
        dn_pulse_nxt = '0;
        if (is_press) begin
            // A new press pre-empts whatever lever is held or stretching.
            state_nxt = HELD;
            sel_nxt   = mom_off[MOM_W-1:0];
            up_nxt    = (cursor_action == 2'd1);
            hold_nxt  = HOLD_W'(1);
            if (cursor_action == 2'd1) up_pulse_nxt = press_onehot;
            else                       dn_pulse_nxt = press_onehot;
        end else begin
            case (state)
                HELD: begin
                    hold_nxt = hold_inc;
                    if (evt) begin
                        if (hold_cnt >= HOLD_MAX) begin
                            state_nxt = IDLE;
                            hold_nxt  = '0;
                        end else begin
                            state_nxt = STRETCH;
                        end
                    end else if (rep_fire) begin
                        if (mom_is_up) up_pulse_nxt = mom_onehot;
                        else           dn_pulse_nxt = mom_onehot;
                    end
                end
                STRETCH: begin
                    if (hold_cnt >= HOLD_MAX) begin
                        state_nxt = IDLE;
                        hold_nxt  = '0;
                    end else begin
                        hold_nxt = hold_inc;
                    end
                end
                default: hold_nxt = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            prev_idx       <= 5'd0;
            prev_act       <= 2'd3;
            mom_sel        <= '0;
            mom_is_up      <= 1'b0;
            hold_cnt       <= '0;
            mom_up_pulse   <= '0;
            mom_dn_pulse   <= '0;
            toggle_sw      <= TOGGLE_INIT;
            toggle_changed <= 1'b0;
        end else begin
            state          <= state_nxt;
            prev_idx       <= cursor_index;
            prev_act       <= cursor_action;
            mom_sel        <= sel_nxt;
            mom_is_up      <= up_nxt;
            hold_cnt       <= hold_nxt;
            mom_up_pulse   <= up_pulse_nxt;
            mom_dn_pulse   <= dn_pulse_nxt;
            toggle_sw      <= toggle_nxt;
            toggle_changed <= (toggle_nxt != toggle_sw);
        end
    end

endmodule
